// File: rtl/ssm_rd.sv
// ssm_rd: replays stored packets from the 16-slot x 128-word packet RAM as a 134-bit packet stream.
// Build option SSM_RD_LATENCY_EN: word TS_WORD carries residence latency instead of the stored timestamp.
module ssm_rd #(
  parameter int RD_LAT     = 2,
  parameter int TS_WORD    = 5,
  parameter int SLOT_WORDS = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         reset_rd,
  input  logic         in_ssm_rd_start,
  input  logic [4:0]   in_ssm_rd_pkt_num,
  input  logic         in_ssm_rd_alf,
  input  logic [63:0]  lcm2ssm_rd_time,
  output logic [10:0]  ssm_rd_addr,
  output logic         ssm_rd_rden,
  input  logic [133:0] ssm_rd_rdata,
  output logic [133:0] out_ssm_rd_data,
  output logic         out_ssm_rd_data_wr,
  output logic         out_ssm_rd_valid,
  output logic         out_ssm_rd_valid_wr,
  output logic         out_ssm_rd_busy,
  output logic         out_ssm_rd_done,
  output logic         out_ssm_rd_err
);

  localparam int         WB        = $clog2(SLOT_WORDS);
  localparam logic [7:0] LAST_WORD = 8'(SLOT_WORDS - 1);
  localparam logic [7:0] ISSUE_END = 8'(SLOT_WORDS);
  localparam logic [7:0] TS_IDX    = 8'(TS_WORD);

  typedef enum logic [2:0] {
    IDLE_S,
    WAIT_S,
    READ_S,
    GAP_S,
    DONE_S,
    CLEAR_S
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          slot_cnt_q, slot_cnt_d;
  logic [4:0]          remain_q, remain_d;
  logic [7:0]          wcnt_q, wcnt_d;
  logic [7:0]          issue_q, issue_d;
  logic [RD_LAT-1:0]   tag_q, tag_d;
  logic [10:0]         addr_q, addr_d;
  logic                rden_q, rden_d;
  logic [133:0]        data_q, data_d;
  logic                data_wr_q, data_wr_d;
  logic                valid_q, valid_d;
  logic                valid_wr_q, valid_wr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                ret_valid;
  logic                advance;
`ifdef SSM_RD_LATENCY_EN
  logic                ts_q, ts_d;
`endif

  // The oldest tag bit lines up with the RAM data of the read it marks.
  assign ret_valid = tag_q[RD_LAT-1];

  always_comb begin
    state_d    = state_q;
    slot_cnt_d = slot_cnt_q;
    remain_d   = remain_q;
    wcnt_d     = wcnt_q;
    issue_d    = issue_q;
    tag_d      = RD_LAT'({tag_q, rden_q});
    addr_d     = addr_q;
    rden_d     = 1'b0;
    data_d     = data_q;
    data_wr_d  = 1'b0;
    valid_d    = 1'b0;
    valid_wr_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    advance    = 1'b0;
`ifdef SSM_RD_LATENCY_EN
    ts_d       = 1'b0;
`endif

    case (state_q)
      IDLE_S: begin
        if (in_ssm_rd_start) begin
          if (in_ssm_rd_pkt_num != 5'd0 && in_ssm_rd_pkt_num <= 5'd16) begin
            remain_d   = in_ssm_rd_pkt_num;
            slot_cnt_d = 4'd0;
            busy_d     = 1'b1;
            state_d    = WAIT_S;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      WAIT_S: begin
        if (!in_ssm_rd_alf) begin
          rden_d  = 1'b1;
          addr_d  = {slot_cnt_q, {WB{1'b0}}};
          issue_d = 8'd1;
          wcnt_d  = 8'd0;
          state_d = READ_S;
        end
      end

      READ_S: begin
        if (issue_q < ISSUE_END) begin
          rden_d  = 1'b1;
          addr_d  = {slot_cnt_q, issue_q[WB-1:0]};
          issue_d = issue_q + 8'd1;
        end
        if (ret_valid) begin
          wcnt_d = wcnt_q + 8'd1;
          data_d = ssm_rd_rdata;
`ifdef SSM_RD_LATENCY_EN
          ts_d   = (wcnt_q == TS_IDX);
`endif
          if (wcnt_q == 8'd0) begin
            // A slot that does not open with a head is skipped without output.
            if (ssm_rd_rdata[133:132] != 2'b01) begin
              err_d   = 1'b1;
              advance = 1'b1;
            end else begin
              data_wr_d = 1'b1;
            end
          end else if (ssm_rd_rdata[133:132] == 2'b10) begin
            data_wr_d  = 1'b1;
            valid_d    = 1'b1;
            valid_wr_d = 1'b1;
            advance    = 1'b1;
          end else if (ssm_rd_rdata[133:132] == 2'b01 || wcnt_q == LAST_WORD) begin
            // Close the broken packet with a forced tail so downstream framing stays sane.
            data_d[133:132] = 2'b10;
            data_wr_d       = 1'b1;
            valid_wr_d      = 1'b1;
            err_d           = 1'b1;
            advance         = 1'b1;
          end else begin
            data_wr_d = 1'b1;
          end
        end
        if (advance) begin
          rden_d     = 1'b0;
          tag_d      = '0;
          issue_d    = 8'd0;
          wcnt_d     = 8'd0;
          slot_cnt_d = slot_cnt_q + 4'd1;
          remain_d   = remain_q - 5'd1;
          state_d    = (remain_q == 5'd1) ? DONE_S : GAP_S;
        end
      end

      GAP_S: state_d = WAIT_S;

      DONE_S: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE_S;
      end

      CLEAR_S: begin
        if (!reset_rd) state_d = IDLE_S;
      end

      default: state_d = IDLE_S;
    endcase

    if (reset_rd) begin
      state_d    = CLEAR_S;
      rden_d     = 1'b0;
      tag_d      = '0;
      issue_d    = 8'd0;
      wcnt_d     = 8'd0;
      data_wr_d  = 1'b0;
      valid_d    = 1'b0;
      valid_wr_d = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
`ifdef SSM_RD_LATENCY_EN
      ts_d       = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE_S;
      slot_cnt_q <= 4'd0;
      remain_q   <= 5'd0;
      wcnt_q     <= 8'd0;
      issue_q    <= 8'd0;
      tag_q      <= '0;
      addr_q     <= 11'd0;
      rden_q     <= 1'b0;
      data_q     <= '0;
      data_wr_q  <= 1'b0;
      valid_q    <= 1'b0;
      valid_wr_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef SSM_RD_LATENCY_EN
      ts_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      slot_cnt_q <= slot_cnt_d;
      remain_q   <= remain_d;
      wcnt_q     <= wcnt_d;
      issue_q    <= issue_d;
      tag_q      <= tag_d;
      addr_q     <= addr_d;
      rden_q     <= rden_d;
      data_q     <= data_d;
      data_wr_q  <= data_wr_d;
      valid_q    <= valid_d;
      valid_wr_q <= valid_wr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef SSM_RD_LATENCY_EN
      ts_q       <= ts_d;
`endif
    end
  end

`ifdef SSM_RD_LATENCY_EN
  // Latency uses the time seen while the word is on the output.
  assign out_ssm_rd_data = ts_q ? {data_q[133:64], lcm2ssm_rd_time - data_q[63:0]} : data_q;
`else
  logic unused_time;
  assign unused_time     = ^lcm2ssm_rd_time;
  assign out_ssm_rd_data = data_q;
`endif

  assign ssm_rd_addr         = addr_q;
  assign ssm_rd_rden         = rden_q;
  assign out_ssm_rd_data_wr  = data_wr_q;
  assign out_ssm_rd_valid    = valid_q;
  assign out_ssm_rd_valid_wr = valid_wr_q;
  assign out_ssm_rd_busy     = busy_q;
  assign out_ssm_rd_done     = done_q;
  assign out_ssm_rd_err      = err_q;

endmodule

// File: tb/tb_ssm_rd.sv
// tb_ssm_rd: directed-vector bench for ssm_rd with a behavioural RD_LAT=2 packet RAM.
module tb_ssm_rd;
  localparam int RD_LAT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         reset_rd;
  logic         start;
  logic [4:0]   pkt_num;
  logic         alf;
  logic [63:0]  ltime;
  logic [10:0]  addr;
  logic         rden;
  logic [133:0] rdata;
  logic [133:0] data;
  logic         data_wr, valid, valid_wr, busy, done, err;

  logic [133:0] mem [0:2047];
  logic [133:0] p1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rden_cnt = 0;
  int vgood = 0;
  int vbad = 0;
  int done_cnt = 0;
  logic [133:0] q_data [$];
  int           q_cyc  [$];

  always #5 clk = ~clk;

  ssm_rd #(.RD_LAT(RD_LAT), .TS_WORD(5), .SLOT_WORDS(128)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .reset_rd            (reset_rd),
    .in_ssm_rd_start     (start),
    .in_ssm_rd_pkt_num   (pkt_num),
    .in_ssm_rd_alf       (alf),
    .lcm2ssm_rd_time     (ltime),
    .ssm_rd_addr         (addr),
    .ssm_rd_rden         (rden),
    .ssm_rd_rdata        (rdata),
    .out_ssm_rd_data     (data),
    .out_ssm_rd_data_wr  (data_wr),
    .out_ssm_rd_valid    (valid),
    .out_ssm_rd_valid_wr (valid_wr),
    .out_ssm_rd_busy     (busy),
    .out_ssm_rd_done     (done),
    .out_ssm_rd_err      (err)
  );

  // Two-cycle read RAM: address sampled with rden, data valid two edges later.
  always @(posedge clk) begin
    if (rden) p1 <= mem[addr];
    rdata <= p1;
    cyc   <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rden === 1'b1) rden_cnt = rden_cnt + 1;
    if (data_wr === 1'b1) begin
      q_data.push_back(data);
      q_cyc.push_back(cyc);
    end
    if (valid_wr === 1'b1) begin
      if (valid === 1'b1) vgood = vgood + 1;
      else vbad = vbad + 1;
      $display("[TB] cyc %0d packet end valid=%0b tail=%h", cyc, valid, data[133:120]);
    end
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      $display("[TB] cyc %0d replay done err=%0b", cyc, err);
    end
  end

  function automatic logic [133:0] mkw(input int slot, input int idx, input int len, input bit notail);
    logic [133:0] w;
    w = '0;
    if (idx == 0) w[133:132] = 2'b01;
    else if (!notail && idx == len - 1) w[133:132] = 2'b10;
    else w[133:132] = 2'b11;
    w[131:128] = 4'(slot);
    w[127:120] = 8'(idx);
    w[63:0]    = 64'(slot * 4096 + idx + 1);
    return w;
  endfunction

  task automatic load_pkt(input int slot, input int len, input bit notail);
    for (int i = 0; i < len; i++) mem[slot * 128 + i] = mkw(slot, i, len, notail);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; reset_rd = 1'b0; start = 1'b0; pkt_num = 5'd0; alf = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start(input logic [4:0] n, output int edge_cyc);
    @(negedge clk);
    pkt_num = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edge_cyc = cyc;
  endtask

  task automatic wait_done(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cnt > base) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    int st;
    do_reset();
    #1;
    tests++; if (data_wr !== 1'b0) begin fails++; $display("FAIL reset_data_wr got=%b exp=0", data_wr); end
    tests++; if (valid_wr !== 1'b0) begin fails++; $display("FAIL reset_valid_wr got=%b exp=0", valid_wr); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err); end
    tests++; if (rden !== 1'b0) begin fails++; $display("FAIL reset_rden got=%b exp=0", rden); end
    load_pkt(0, 8, 1'b0);
    pulse_start(5'd1, st);
    #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL start_busy got=%b exp=1", busy); end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    tests++; if (busy !== 1'b0 || rden !== 1'b0) begin fails++; $display("FAIL rst_midrun busy=%b rden=%b exp=0/0", busy, rden); end
    rst = 1'b0;
  endtask

  task automatic test_two_slots();
    int st, base, db, vg, vb;
    bit ok;
    logic [133:0] w;
    do_reset();
    load_pkt(0, 3, 1'b0);
    load_pkt(1, 8, 1'b0);
    base = q_data.size(); db = done_cnt; vg = vgood; vb = vbad;
    pulse_start(5'd2, st);
    wait_done(db, 300, ok);
    tests++; if (!ok) begin fails++; $display("FAIL two_slots_timeout done not seen"); end
    #1;
    tests++; if (q_data.size() - base !== 11) begin fails++; $display("FAIL two_slots_count got=%0d exp=11", q_data.size() - base); end
    if (q_data.size() - base >= 11) begin
      tests++; if (q_cyc[base] - st !== 2 + RD_LAT) begin fails++; $display("FAIL start_latency got=%0d exp=%0d", q_cyc[base] - st, 2 + RD_LAT); end
      tests++; if (q_cyc[base + 3] - q_cyc[base] < 3 + RD_LAT + 2) begin fails++; $display("FAIL head_gap got=%0d exp>=%0d", q_cyc[base + 3] - q_cyc[base], 5 + RD_LAT); end
      w = mkw(0, 2, 3, 1'b0);
      tests++; if (q_data[base + 2] !== w) begin fails++; $display("FAIL tail0_word got=%h exp=%h", q_data[base + 2], w); end
      w = mkw(1, 0, 8, 1'b0);
      tests++; if (q_data[base + 3] !== w) begin fails++; $display("FAIL head1_word got=%h exp=%h", q_data[base + 3], w); end
      w = mkw(1, 7, 8, 1'b0);
      tests++; if (q_data[base + 10] !== w) begin fails++; $display("FAIL tail1_word got=%h exp=%h", q_data[base + 10], w); end
    end
    tests++; if (vgood - vg !== 2 || vbad - vb !== 0) begin fails++; $display("FAIL two_slots_valid good=%0d bad=%0d exp=2/0", vgood - vg, vbad - vb); end
    tests++; if (done_cnt - db !== 1) begin fails++; $display("FAIL two_slots_done got=%0d exp=1", done_cnt - db); end
    tests++; if (err !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL two_slots_flags err=%b busy=%b exp=0/0", err, busy); end
  endtask

  task automatic test_timestamp();
    int st, base, db;
    bit ok;
    logic [133:0] w;
    do_reset();
    load_pkt(0, 8, 1'b0);
    mem[5][63:0] = 64'h100;
    ltime = 64'h180;
    base = q_data.size(); db = done_cnt;
    pulse_start(5'd1, st);
    wait_done(db, 200, ok);
    tests++; if (!ok) begin fails++; $display("FAIL ts_timeout done not seen"); end
    w = mem[5];
`ifdef SSM_RD_LATENCY_EN
    w[63:0] = 64'h80;
`else
    w[63:0] = 64'h100;
`endif
    tests++;
    if (q_data.size() - base < 6) begin fails++; $display("FAIL ts_count got=%0d exp>=6", q_data.size() - base); end
    else if (q_data[base + 5] !== w) begin fails++; $display("FAIL ts_word got=%h exp=%h", q_data[base + 5], w); end
  endtask

  task automatic test_alf();
    int st, base, db, rb, alf_cyc;
    bit ok;
    do_reset();
    load_pkt(0, 4, 1'b0);
    alf = 1'b1;
    base = q_data.size(); db = done_cnt; rb = rden_cnt;
    pulse_start(5'd1, st);
    repeat (20) @(negedge clk);
    #1;
    tests++; if (rden_cnt - rb !== 0) begin fails++; $display("FAIL alf_rden got=%0d exp=0", rden_cnt - rb); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL alf_busy got=%b exp=1", busy); end
    alf = 1'b0;
    alf_cyc = cyc;
    wait_done(db, 200, ok);
    tests++; if (!ok) begin fails++; $display("FAIL alf_timeout done not seen"); end
    tests++;
    if (q_data.size() - base !== 4) begin fails++; $display("FAIL alf_count got=%0d exp=4", q_data.size() - base); end
    else if (q_cyc[base] - alf_cyc !== 2 + RD_LAT) begin fails++; $display("FAIL alf_latency got=%0d exp=%0d", q_cyc[base] - alf_cyc, 2 + RD_LAT); end
  endtask

  task automatic test_empty_slot();
    int st, base, db, vg;
    bit ok;
    logic [133:0] w;
    do_reset();
    load_pkt(0, 3, 1'b0);
    mem[128] = '0;
    load_pkt(2, 4, 1'b0);
    base = q_data.size(); db = done_cnt; vg = vgood;
    pulse_start(5'd3, st);
    wait_done(db, 300, ok);
    tests++; if (!ok) begin fails++; $display("FAIL empty_timeout done not seen"); end
    tests++; if (q_data.size() - base !== 7) begin fails++; $display("FAIL empty_count got=%0d exp=7", q_data.size() - base); end
    w = mkw(2, 0, 4, 1'b0);
    tests++;
    if (q_data.size() - base < 4) begin fails++; $display("FAIL empty_slot2_head missing words got=%0d", q_data.size() - base); end
    else if (q_data[base + 3] !== w) begin fails++; $display("FAIL empty_slot2_head got=%h exp=%h", q_data[base + 3], w); end
    tests++; if (vgood - vg !== 2) begin fails++; $display("FAIL empty_valid got=%0d exp=2", vgood - vg); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL empty_err got=%b exp=1", err); end
  endtask

  task automatic test_no_tail();
    int st, base, db, vg, vb;
    bit ok;
    logic [133:0] w;
    do_reset();
    load_pkt(0, 128, 1'b1);
    base = q_data.size(); db = done_cnt; vg = vgood; vb = vbad;
    pulse_start(5'd1, st);
    wait_done(db, 500, ok);
    tests++; if (!ok) begin fails++; $display("FAIL notail_timeout done not seen"); end
    tests++; if (q_data.size() - base !== 128) begin fails++; $display("FAIL notail_count got=%0d exp=128", q_data.size() - base); end
    w = mkw(0, 127, 128, 1'b1);
    w[133:132] = 2'b10;
    tests++;
    if (q_data.size() - base < 128) begin fails++; $display("FAIL notail_last missing words got=%0d", q_data.size() - base); end
    else if (q_data[base + 127] !== w) begin fails++; $display("FAIL notail_last got=%h exp=%h", q_data[base + 127], w); end
    tests++; if (vbad - vb !== 1 || vgood - vg !== 0) begin fails++; $display("FAIL notail_valid bad=%0d good=%0d exp=1/0", vbad - vb, vgood - vg); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL notail_err got=%b exp=1", err); end
  endtask

  task automatic test_bad_pkt_num();
    int st;
    do_reset();
    pulse_start(5'd0, st);
    #1;
    tests++; if (busy !== 1'b0 || err !== 1'b1) begin fails++; $display("FAIL pkt0 busy=%b err=%b exp=0/1", busy, err); end
    @(negedge clk); reset_rd = 1'b1;
    @(negedge clk); reset_rd = 1'b0;
    #1;
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_rd_err_clear got=%b exp=0", err); end
    @(negedge clk);
    pulse_start(5'd17, st);
    #1;
    tests++; if (busy !== 1'b0 || err !== 1'b1) begin fails++; $display("FAIL pkt17 busy=%b err=%b exp=0/1", busy, err); end
  endtask

  task automatic test_reset_rd();
    int st, base, db, vg;
    bit ok;
    logic [133:0] w;
    do_reset();
    load_pkt(0, 8, 1'b0);
    base = q_data.size(); db = done_cnt;
    pulse_start(5'd1, st);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (q_data.size() - base >= 5) begin ok = 1'b1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL rdclr_timeout word 4 not seen"); end
    reset_rd = 1'b1;
    repeat (3) @(negedge clk);
    reset_rd = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    tests++; if (q_data.size() - base !== 5) begin fails++; $display("FAIL rdclr_count got=%0d exp=5", q_data.size() - base); end
    tests++; if (busy !== 1'b0 || rden !== 1'b0) begin fails++; $display("FAIL rdclr_idle busy=%b rden=%b exp=0/0", busy, rden); end
    tests++; if (done_cnt - db !== 0) begin fails++; $display("FAIL rdclr_done got=%0d exp=0", done_cnt - db); end
    vg = vgood;
    pulse_start(5'd1, st);
    wait_done(db, 200, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rdclr_restart_timeout done not seen"); end
    w = mkw(0, 0, 8, 1'b0);
    tests++;
    if (q_data.size() - base !== 13) begin fails++; $display("FAIL rdclr_restart_count got=%0d exp=13", q_data.size() - base); end
    else if (q_data[base + 5] !== w) begin fails++; $display("FAIL rdclr_restart_head got=%h exp=%h", q_data[base + 5], w); end
    tests++; if (vgood - vg !== 1) begin fails++; $display("FAIL rdclr_restart_valid got=%0d exp=1", vgood - vg); end
  endtask

  initial begin
    rst = 1'b1; reset_rd = 1'b0; start = 1'b0; pkt_num = 5'd0; alf = 1'b0; ltime = 64'h180;
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    test_reset();
    test_two_slots();
    test_timestamp();
    test_alf();
    test_empty_slot();
    test_no_tail();
    test_bad_pkt_num();
    test_reset_rd();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
